// File: rtl/data_sram_responder.sv
// Word-organised data RAM answering the memory stage's en/we/addr/wdata requests with
// a fixed one-cycle read latency, plus a backdoor init port, range error flag and counters.
module data_sram_responder #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_we,
    input  logic [31:0]       data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic [31:0]       data_sram_rdata,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [31:0]       init_wdata,
    output logic              sram_err,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt,
    output logic [15:0]       err_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [29:0]       off_word;
    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic              init_hit;
    logic              req_ok;
    logic              req_bad;
    logic              is_write;
    logic [31:0]       merged;
    logic [31:0]       resp_word;

    // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
    assign off_word = 30'((data_sram_addr - BASE_ADDR) >> 2);
    assign in_range = (off_word >> ADDR_W) == '0;
    assign idx      = off_word[ADDR_W-1:0];
    assign req_ok   = data_sram_en && in_range;
    assign req_bad  = data_sram_en && !in_range;
    assign is_write = |data_sram_we;
    assign init_hit = init_we && (init_addr == idx);

    always_comb begin
        merged = mem[idx];
        for (int i = 0; i < 4; i++) begin
            if (data_sram_we[i]) begin
                merged[8*i +: 8] = data_sram_wdata[8*i +: 8];
            end
        end
    end

    // A same-word init write overrides the whole pipeline word, including what is read back.
    assign resp_word = init_hit ? init_wdata : merged;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_sram_rdata <= 32'h0;
            sram_err        <= 1'b0;
            rd_cnt          <= 32'h0;
            wr_cnt          <= 32'h0;
            err_cnt         <= 16'h0;
        end else begin
            sram_err <= req_bad;
            if (req_ok) begin
                data_sram_rdata <= resp_word;
                if (is_write) begin
                    wr_cnt <= wr_cnt + 32'd1;
                end else begin
                    rd_cnt <= rd_cnt + 32'd1;
                end
                if (is_write && !init_hit) begin
                    mem[idx] <= merged;
                end
            end else if (req_bad) begin
                data_sram_rdata <= 32'h0;
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end
            if (init_we) begin
                mem[init_addr] <= init_wdata;
            end
        end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized self-checking bench for data_sram_responder against an array-based model,
// with directed scenarios whose results are also pinned as literals.
module tb_data_sram_responder;
    localparam int          ADDR_W = 6;
    localparam int          DEPTH  = 2 ** ADDR_W;
    localparam logic [31:0] BASE   = 32'h0000_1000;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [3:0]        we;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [31:0]       init_wdata;
    logic              sram_err;
    logic [31:0]       rd_cnt;
    logic [31:0]       wr_cnt;
    logic [15:0]       err_cnt;

    data_sram_responder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .data_sram_en(en), .data_sram_we(we), .data_sram_addr(addr),
        .data_sram_wdata(wdata), .data_sram_rdata(rdata),
        .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata),
        .sram_err(sram_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit run_cmp = 1'b0;

    // Reference model: plain word array plus expected output values.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] e_rdata;
    logic        e_err;
    logic [31:0] e_rd;
    logic [31:0] e_wr;
    logic [15:0] e_errc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        logic [31:0] off;
        int          w;
        logic [31:0] word;
        if (reset) begin
            e_rdata = 0; e_err = 0; e_rd = 0; e_wr = 0; e_errc = 0;
        end else begin
            e_err = 1'b0;
            if (en) begin
                off = addr - BASE;
                if (off < 32'(4 * DEPTH)) begin
                    w = int'(off / 4);
                    word = m_mem[w];
                    for (int b = 0; b < 4; b++)
                        if (we[b]) word[8*b +: 8] = wdata[8*b +: 8];
                    if (init_we && int'(init_addr) == w) word = init_wdata;
                    m_mem[w] = word;
                    e_rdata = word;
                    if (we != 4'b0) e_wr = e_wr + 1; else e_rd = e_rd + 1;
                end else begin
                    e_rdata = 0;
                    e_err = 1'b1;
                    if (e_errc != 16'hFFFF) e_errc = e_errc + 1;
                end
            end
            if (init_we) m_mem[init_addr] = init_wdata;
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("rdata", rdata, e_rdata);
            chk("sram_err", 32'(sram_err), 32'(e_err));
            chk("rd_cnt", rd_cnt, e_rd);
            chk("wr_cnt", wr_cnt, e_wr);
            chk("err_cnt", 32'(err_cnt), 32'(e_errc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic e, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d);
        en = e; we = w; addr = a; wdata = d; init_we = 1'b0;
    endtask

    task automatic ini(input logic [ADDR_W-1:0] i, input logic [31:0] d);
        init_we = 1'b1; init_addr = i; init_wdata = d;
    endtask

    initial begin
        logic [31:0] a;
        reset = 1'b1;
        req(0, 4'h0, 32'h0, 32'h0);
        init_addr = '0; init_wdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        tick(); tick();
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_err", 32'(sram_err), 32'h0);
        chk("reset_rd_cnt", rd_cnt, 32'h0);
        reset = 1'b0;
        run_cmp = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            req(0, 4'h0, 32'h0, 32'h0);
            ini(ADDR_W'(i), $urandom);
            tick();
        end

        // Init then read of word 5
        req(0, 4'h0, 32'h0, 32'h0); ini(6'd5, 32'hDEAD_BEEF); tick();
        req(1, 4'h0, BASE + 32'h14, 32'h0); tick();
        chk("t1_rdata", rdata, 32'hDEAD_BEEF);
        chk("t1_rd_cnt", rd_cnt, 32'd1);

        // Partial byte write merge
        req(0, 4'h0, 32'h0, 32'h0); ini(6'd5, 32'h1122_3344); tick();
        req(1, 4'b0101, BASE + 32'h14, 32'hAABB_CCDD); tick();
        chk("t2_merge", rdata, 32'h11BB_33DD);
        chk("t2_wr_cnt", wr_cnt, 32'd1);
        req(1, 4'h0, BASE + 32'h14, 32'h0); tick();
        chk("t2_readback", rdata, 32'h11BB_33DD);

        // Back-to-back write/read and consecutive reads
        req(1, 4'hF, BASE + 32'h8, 32'h5); tick();
        req(1, 4'h0, BASE + 32'h8, 32'h0); tick();
        chk("t3_b2b", rdata, 32'h5);
        req(1, 4'h0, BASE + 32'h0, 32'h0); tick();
        req(1, 4'h0, BASE + 32'h4, 32'h0); tick();
        req(1, 4'h0, BASE + 32'h8, 32'h0); tick();
        chk("t3_seq_w2", rdata, 32'h5);

        // Out of range, both above the top and below the base
        req(1, 4'h0, BASE + 32'(4 * DEPTH), 32'h0); tick();
        chk("t4_rdata", rdata, 32'h0);
        chk("t4_err", 32'(sram_err), 32'h1);
        chk("t4_err_cnt", 32'(err_cnt), 32'd1);
        req(0, 4'h0, 32'h0, 32'h0); tick();
        chk("t4_err_pulse", 32'(sram_err), 32'h0);
        req(1, 4'hF, BASE - 32'h4, 32'hFFFF_FFFF); tick();
        chk("t4_wrap_err", 32'(sram_err), 32'h1);
        chk("t4_wrap_cnt", 32'(err_cnt), 32'd2);
        chk("t4_wrap_wr_cnt", wr_cnt, 32'd2);

        // Init/pipeline collision on word 3
        req(1, 4'hF, BASE + 32'hC, 32'h2); ini(6'd3, 32'h1); tick();
        chk("t5_rdata", rdata, 32'h1);
        chk("t5_wr_cnt", wr_cnt, 32'd3);
        req(1, 4'h0, BASE + 32'hE, 32'h0); tick();
        chk("t5_mem", rdata, 32'h1);

        // Reset mid-burst; memory must survive
        for (int i = 0; i < 4; i++) begin
            req(1, 4'(i + 1), BASE + 32'h20 + 32'(4 * i), $urandom); tick();
        end
        req(1, 4'hF, BASE + 32'h14, 32'hFFFF_FFFF);
        reset = 1'b1;
        #1;
        chk("t6_async_rdata", rdata, 32'h0);
        chk("t6_async_wr_cnt", wr_cnt, 32'h0);
        chk("t6_async_err_cnt", 32'(err_cnt), 32'h0);
        ini(6'd5, 32'h0BAD_0BAD); en = 1'b1;
        tick(); tick();
        reset = 1'b0;
        req(1, 4'h0, BASE + 32'h15, 32'h0); tick();
        chk("t6_mem_kept", rdata, 32'h11BB_33DD);
        chk("t6_rd_cnt", rd_cnt, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            req($urandom_range(0, 3) != 0,
                ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, a, $urandom);
            if ($urandom_range(0, 5) == 0) begin
                ini(($urandom_range(0, 1) != 0) ? ADDR_W'((a - BASE) >> 2) : ADDR_W'($urandom),
                    $urandom);
            end
            tick();
        end

        req(0, 4'h0, 32'h0, 32'h0);
        tick(); tick();
        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
